wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Write-back stage of the 5-stage MIPS pipeline; consumes mem_stage's ms_to_ws_bus (133 b).
//  Commits byte-strobed GPR writes and drives the debug trace.
//  Owns a CP0 subset (BadVAddr, Count, Compare, Status, Cause, EPC) and raises the pipeline-wide flush (ws_ex/ws_eret).
// PARAMETERS
//  EX_ENTRY   32'hBFC0_0380  exception vector driven on ws_flush_pc when ws_ex
//  BUS_WD     133            ms_to_ws_bus width (= `MS_TO_WS_BUS_WD)
// PORTS
//  clk               in   1    single clock, rising edge
//  resetn            in   1    asynchronous, active-low reset
//  ms_to_ws_valid    in   1    mem_stage output valid (already gated by ws_ex/ws_eret)
//  ms_to_ws_bus      in   133  {s1_index,s1_found,tlb_sign,tlbp,tlbr,tlbwi,excode,badvaddr,cp0_addr,ex,bd,eret,syscall,mfc0,mtc0,gr_strb,dest,result,pc}
//  ws_allowin        out  1    stage can accept
//  ws_to_rf_bus      out  41   {rf_we[3:0],rf_waddr[4:0],rf_wdata[31:0]} to regfile
//  ws_fwd_bus        out  41   {fwd_valid[3:0],dest[4:0],data[31:0]} to decode bypass
//  ws_ex             out  1    committing instruction carries exception (flush)
//  ws_eret           out  1    committing ERET (flush)
//  ws_flush_pc       out  32   EX_ENTRY when ws_ex, EPC when ws_eret
//  ws_int_pending    out  1    Status.IE & !Status.EXL & |(Cause.IP & Status.IM)
//  ext_int_in        in   6    hardware interrupt lines -> Cause.IP[7:2]
//  debug_wb_pc       out  32   committed pc
//  debug_wb_rf_wen   out  4    = rf_we
//  debug_wb_rf_wnum  out  5    = rf_waddr
//  debug_wb_rf_wdata out  32   = rf_wdata
// BEHAVIOUR
//  - Reset (resetn=0, async): ws_valid=0; Status=32'h0040_0000 (BEV=1); Cause=0; EPC=0; BadVAddr=0; Count=0; Compare=0; tick=0.
//    Hence all outputs are 0 except ws_allowin=1 and ws_flush_pc=EX_ENTRY.
//  - Handshake: ws_ready_go=1; ws_allowin=!ws_valid|ws_ready_go (always 1).
//    Bus captured on ms_to_ws_valid&ws_allowin; ws_valid<=ms_to_ws_valid.
//  - ws_ex=ws_valid&ex, ws_eret=ws_valid&eret, both combinational, single-cycle.
//    Next cycle ws_valid=0 (upstream gates valid).
//  - rf_we={4{ws_valid&!ex}} & gr_strb. Partial strobes (LWL/LWR) pass unchanged.
//  - rf_wdata = mfc0 ? cp0_rdata : result. fwd_valid=rf_we.
//  - CP0 address = {rd,sel}: 0x40 BadVAddr (RO), 0x48 Count, 0x58 Compare, 0x60 Status, 0x68 Cause, 0x70 EPC.
//    Unmapped reads return 0; unmapped writes are ignored.
//  - MTC0 (ws_valid&mtc0&!ex) writes result at the clock edge. Writable fields:
//    Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8]; EPC and Count full width.
//    A Compare write also clears Cause.TI.
//  - Exception commit (ws_ex):
//    - when !EXL: EPC<=bd?pc-4:pc and Cause.BD<=bd;
//    - always: ExcCode<=excode, EXL<=1;
//    - BadVAddr<=badvaddr when excode is AdEL(4), AdES(5), TLBL(2), TLBS(3) or Mod(1).
//    - MTC0 is suppressed in the same cycle.
//  - ERET commit: EXL<=0; ws_flush_pc=EPC (combinational, current EPC value).
//  - Count: tick toggles every cycle; Count+=1 when tick=1, wrapping at 2^32.
//    An MTC0 Count write has priority over the increment.
//  - TI: set when Count==Compare; cleared only by a Compare write.
//    A same-cycle match and Compare write resolve as cleared. Cause.IP[7]=TI|ext_int_in[5].
//  - Cause.IP[7:2] are sampled from ext_int_in every cycle (registered, 1-cycle latency).
//  - tlbp/tlbr/tlbwi/tlb_sign are carried but unused here; the TLB block consumes them later.
// STRUCTURE
//  - mycpu.h: `MS_TO_WS_BUS_WD, `WS_TO_RF_BUS_WD, `WS_FWD_BUS_WD, CP0 address constants (`CR_STATUS...), ExcCode constants.
//  - Sub-module wb_cp0_regs holds the CP0 registers, Count/TI logic and the read mux.
//    It takes mtc0_we/addr/wdata, ex/eret commit controls and ext_int_in.
//    It returns rdata, epc and int_pending.
//  - wb_stage itself holds the pipeline register, RF/forward/debug muxing and flush generation.
// TESTING
//  - Plain ALU: gr_strb=4'hF, dest=5, result=32'h1234_5678, pc=32'hBFC0_0100
//    -> next cycle rf_we=F, wnum=5, wdata=32'h1234_5678, debug_wb_pc=32'hBFC0_0100.
//  - LWL partial: gr_strb=4'b1100 -> rf_we=4'b1100, fwd_valid=4'b1100, data unchanged.
//  - AdEL in delay slot: ex=1, bd=1, excode=4, badvaddr=32'h8000_0001, pc=32'hBFC0_0204
//    -> ws_ex=1, rf_we=0, flush_pc=BFC0_0380; then EPC=BFC0_0200, Cause.BD=1, ExcCode=4, BadVAddr=8000_0001, EXL=1.
//  - Nested exception with EXL=1 -> EPC unchanged, ExcCode updated. Then ERET -> ws_eret=1, flush_pc=EPC, then EXL=0.
//  - MTC0 Compare=3, Count=0 -> TI sets once Count reaches 3 (~6 cycles later).
//    MTC0 Compare again clears TI; with IE=1, IM7=1, EXL=0, ws_int_pending follows TI.
//  - Async reset asserted mid-stream with ws_valid=1 -> rf_we=0, ws_ex=0 immediately; all CP0 registers at reset values.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage: the mem->wb bus layout,
// CP0 register addresses and the exception codes the stage cares about.
package wb_stage_pkg;

   localparam int MS_TO_WS_BUS_WD = 133;
   localparam int WS_TO_RF_BUS_WD = 41;
   localparam int WS_FWD_BUS_WD   = 41;

   // CP0 addresses are {rd[4:0], sel[2:0]}
   localparam logic [7:0] CR_BADVADDR = 8'h40;
   localparam logic [7:0] CR_COUNT    = 8'h48;
   localparam logic [7:0] CR_COMPARE  = 8'h58;
   localparam logic [7:0] CR_STATUS   = 8'h60;
   localparam logic [7:0] CR_CAUSE    = 8'h68;
   localparam logic [7:0] CR_EPC      = 8'h70;

   localparam logic [4:0] EXC_MOD  = 5'd1;
   localparam logic [4:0] EXC_TLBL = 5'd2;
   localparam logic [4:0] EXC_TLBS = 5'd3;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   // First field is the MSB end of ms_to_ws_bus.
   typedef struct packed {
      logic [3:0]  s1_index;
      logic        s1_found;
      logic        tlb_sign;
      logic        tlbp;
      logic        tlbr;
      logic        tlbwi;
      logic [4:0]  excode;
      logic [31:0] badvaddr;
      logic [7:0]  cp0_addr;
      logic        ex;
      logic        bd;
      logic        eret;
      logic        syscall;
      logic        mfc0;
      logic        mtc0;
      logic [3:0]  gr_strb;
      logic [4:0]  dest;
      logic [31:0] result;
      logic [31:0] pc;
   } ms_bus_t;

   function automatic logic loads_badvaddr(input logic [4:0] code);
      return (code == EXC_MOD) || (code == EXC_TLBL) || (code == EXC_TLBS) ||
             (code == EXC_ADEL) || (code == EXC_ADES);
   endfunction

endpackage

// File: rtl/wb_stage_cp0.sv
// CP0 register subset (BadVAddr, Count, Compare, Status, Cause, EPC) with the
// timer-interrupt logic, exception/ERET bookkeeping and the MFC0 read mux.
module wb_cp0_regs
   import wb_stage_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        mtc0_we,
   input  logic [7:0]  addr,
   input  logic [31:0] wdata,
   input  logic        ex_commit,
   input  logic [4:0]  ex_code,
   input  logic        ex_bd,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_badvaddr,
   input  logic        eret_commit,
   input  logic [5:0]  ext_int_in,
   output logic [31:0] rdata,
   output logic [31:0] epc,
   output logic        int_pending
);

   logic [31:0] badvaddr_q, badvaddr_d, count_q, count_d, compare_q, compare_d;
   logic [31:0] epc_q, epc_d;
   logic [7:0]  im_q, im_d;
   logic        exl_q, exl_d, ie_q, ie_d;
   logic        bd_q, bd_d, ti_q, ti_d, tick_q, tick_d;
   logic [1:0]  ip_sw_q, ip_sw_d;
   logic [5:0]  ip_hw_q, ip_hw_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [7:0]  ip;
   logic [31:0] status, cause;

   assign ip     = {ti_q | ip_hw_q[5], ip_hw_q[4:0], ip_sw_q};
   assign status = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
   assign cause  = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};

   always_comb begin
      badvaddr_d = badvaddr_q;
      count_d    = count_q;
      compare_d  = compare_q;
      epc_d      = epc_q;
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ti_d       = ti_q;
      ip_sw_d    = ip_sw_q;
      ip_hw_d    = ext_int_in;
      exccode_d  = exccode_q;
      tick_d     = ~tick_q;

      if (tick_q) count_d = count_q + 32'd1;
      if (count_q == compare_q) ti_d = 1'b1;

      // MTC0 first so that exception / ERET updates below take precedence.
      if (mtc0_we) begin
         case (addr)
            CR_COUNT:   count_d = wdata;
            CR_COMPARE: begin
               compare_d = wdata;
               ti_d      = 1'b0;
            end
            CR_STATUS: begin
               im_d  = wdata[15:8];
               exl_d = wdata[1];
               ie_d  = wdata[0];
            end
            CR_CAUSE:   ip_sw_d = wdata[9:8];
            CR_EPC:     epc_d   = wdata;
            default:    ;
         endcase
      end

      if (eret_commit) exl_d = 1'b0;

      if (ex_commit) begin
         if (!exl_q) begin
            epc_d = ex_bd ? ex_pc - 32'd4 : ex_pc;
            bd_d  = ex_bd;
         end
         exccode_d = ex_code;
         exl_d     = 1'b1;
         if (loads_badvaddr(ex_code)) badvaddr_d = ex_badvaddr;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         badvaddr_q <= '0;
         count_q    <= '0;
         compare_q  <= '0;
         epc_q      <= '0;
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ti_q       <= 1'b0;
         ip_sw_q    <= '0;
         ip_hw_q    <= '0;
         exccode_q  <= '0;
         tick_q     <= 1'b0;
      end else begin
         badvaddr_q <= badvaddr_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         epc_q      <= epc_d;
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ti_q       <= ti_d;
         ip_sw_q    <= ip_sw_d;
         ip_hw_q    <= ip_hw_d;
         exccode_q  <= exccode_d;
         tick_q     <= tick_d;
      end
   end

   always_comb begin
      rdata = 32'h0;
      case (addr)
         CR_BADVADDR: rdata = badvaddr_q;
         CR_COUNT:    rdata = count_q;
         CR_COMPARE:  rdata = compare_q;
         CR_STATUS:   rdata = status;
         CR_CAUSE:    rdata = cause;
         CR_EPC:      rdata = epc_q;
         default:     rdata = 32'h0;
      endcase
   end

   assign epc         = epc_q;
   assign int_pending = ie_q & ~exl_q & (|(ip & im_q));

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: pipeline register, GPR write / forward / debug trace
// generation and the exception/ERET flush toward the front of the pipeline.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter logic [31:0] EX_ENTRY = 32'hBFC0_0380,
   parameter int          BUS_WD   = MS_TO_WS_BUS_WD
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ms_to_ws_valid,
   input  logic [BUS_WD-1:0]          ms_to_ws_bus,
   output logic                       ws_allowin,
   output logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
   output logic [WS_FWD_BUS_WD-1:0]   ws_fwd_bus,
   output logic                       ws_ex,
   output logic                       ws_eret,
   output logic [31:0]                ws_flush_pc,
   output logic                       ws_int_pending,
   input  logic [5:0]                 ext_int_in,
   output logic [31:0]                debug_wb_pc,
   output logic [3:0]                 debug_wb_rf_wen,
   output logic [4:0]                 debug_wb_rf_wnum,
   output logic [31:0]                debug_wb_rf_wdata
);

   ms_bus_t     bus_q, bus_d;
   logic        ws_valid_q, ws_valid_d;
   logic        ws_ready_go, mtc0_we;
   logic [3:0]  rf_we;
   logic [31:0] rf_wdata, cp0_rdata, cp0_epc;
   logic        unused_bits;

   // Valid/ready: a word moves from mem to wb when ms_to_ws_valid & ws_allowin
   // at a rising edge; wb never stalls, so ws_allowin is constantly high.
   assign ws_ready_go = 1'b1;
   assign ws_allowin  = ~ws_valid_q | ws_ready_go;

   always_comb begin
      ws_valid_d = ws_allowin ? ms_to_ws_valid : ws_valid_q;
      bus_d      = bus_q;
      if (ms_to_ws_valid && ws_allowin) bus_d = ms_to_ws_bus;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ws_valid_q <= 1'b0;
         bus_q      <= '0;
      end else begin
         ws_valid_q <= ws_valid_d;
         bus_q      <= bus_d;
      end
   end

   assign ws_ex       = ws_valid_q & bus_q.ex;
   assign ws_eret     = ws_valid_q & bus_q.eret;
   assign ws_flush_pc = ws_eret ? cp0_epc : EX_ENTRY;
   assign mtc0_we     = ws_valid_q & bus_q.mtc0 & ~bus_q.ex;

   assign rf_we    = {4{ws_valid_q & ~bus_q.ex}} & bus_q.gr_strb;
   assign rf_wdata = bus_q.mfc0 ? cp0_rdata : bus_q.result;

   assign ws_to_rf_bus      = {rf_we, bus_q.dest, rf_wdata};
   assign ws_fwd_bus        = {rf_we, bus_q.dest, rf_wdata};
   assign debug_wb_pc       = bus_q.pc;
   assign debug_wb_rf_wen   = rf_we;
   assign debug_wb_rf_wnum  = bus_q.dest;
   assign debug_wb_rf_wdata = rf_wdata;

   // TLB sideband rides along for a later block; syscall is already folded into ex.
   assign unused_bits = ^{bus_q.s1_index, bus_q.s1_found, bus_q.tlb_sign,
                          bus_q.tlbp, bus_q.tlbr, bus_q.tlbwi, bus_q.syscall};

   wb_cp0_regs u_cp0 (
      .clk         (clk),
      .resetn      (resetn),
      .mtc0_we     (mtc0_we),
      .addr        (bus_q.cp0_addr),
      .wdata       (bus_q.result),
      .ex_commit   (ws_ex),
      .ex_code     (bus_q.excode),
      .ex_bd       (bus_q.bd),
      .ex_pc       (bus_q.pc),
      .ex_badvaddr (bus_q.badvaddr),
      .eret_commit (ws_eret),
      .ext_int_in  (ext_int_in),
      .rdata       (cp0_rdata),
      .epc         (cp0_epc),
      .int_pending (ws_int_pending)
   );

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: drives instructions on the falling edge and
// checks trace, flush and CP0 state (read back through MFC0) after each commit.
module tb_wb_stage;
   import wb_stage_pkg::*;

   logic         clk = 1'b0;
   logic         resetn;
   logic         ms_to_ws_valid;
   logic [132:0] ms_to_ws_bus;
   logic         ws_allowin;
   logic [40:0]  ws_to_rf_bus, ws_fwd_bus;
   logic         ws_ex, ws_eret, ws_int_pending;
   logic [31:0]  ws_flush_pc, debug_wb_pc, debug_wb_rf_wdata;
   logic [5:0]   ext_int_in;
   logic [3:0]   debug_wb_rf_wen;
   logic [4:0]   debug_wb_rf_wnum;

   int n_total = 0;
   int n_bad   = 0;

   wb_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .ws_allowin        (ws_allowin),
      .ws_to_rf_bus      (ws_to_rf_bus),
      .ws_fwd_bus        (ws_fwd_bus),
      .ws_ex             (ws_ex),
      .ws_eret           (ws_eret),
      .ws_flush_pc       (ws_flush_pc),
      .ws_int_pending    (ws_int_pending),
      .ext_int_in        (ext_int_in),
      .debug_wb_pc       (debug_wb_pc),
      .debug_wb_rf_wen   (debug_wb_rf_wen),
      .debug_wb_rf_wnum  (debug_wb_rf_wnum),
      .debug_wb_rf_wdata (debug_wb_rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic ms_bus_t blank();
      ms_bus_t b;
      b = '0;
      return b;
   endfunction

   // Present one instruction at the falling edge; return 1 ns after it commits.
   task automatic send(input ms_bus_t b);
      @(negedge clk);
      ms_to_ws_valid = 1'b1;
      ms_to_ws_bus   = b;
      @(posedge clk);
      #1;
   endtask

   task automatic bubble();
      @(negedge clk);
      ms_to_ws_valid = 1'b0;
      ms_to_ws_bus   = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic wr_cp0(input logic [7:0] a, input logic [31:0] v);
      ms_bus_t b;
      b = blank();
      b.mtc0 = 1'b1; b.cp0_addr = a; b.result = v; b.pc = 32'hBFC0_1000;
      send(b);
   endtask

   task automatic rd_cp0(input logic [7:0] a, output logic [31:0] v);
      ms_bus_t b;
      b = blank();
      b.mfc0 = 1'b1; b.cp0_addr = a; b.gr_strb = 4'hF; b.dest = 5'd8;
      b.pc = 32'hBFC0_2000;
      send(b);
      v = debug_wb_rf_wdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ms_bus_t     b;
      logic [31:0] v;
      bit          seen;

      resetn = 1'b0; ms_to_ws_valid = 1'b0; ms_to_ws_bus = '0; ext_int_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_allowin", {31'b0, ws_allowin}, 32'd1);
      chk("rst_flush_pc", ws_flush_pc, 32'hBFC0_0380);
      chk("rst_rf_we", {28'b0, debug_wb_rf_wen}, 32'd0);
      chk("rst_ex_eret", {30'b0, ws_ex, ws_eret}, 32'd0);
      chk("rst_pc", debug_wb_pc, 32'd0);
      chk("rst_int", {31'b0, ws_int_pending}, 32'd0);
      resetn = 1'b1;

      // Move Compare far away so the reset-time Count==Compare match clears.
      wr_cp0(CR_COMPARE, 32'hFFFF_FFF0);

      b = blank(); b.gr_strb = 4'hF; b.dest = 5'd5; b.result = 32'h1234_5678;
      b.pc = 32'hBFC0_0100;
      send(b);
      chk("alu_we", {28'b0, debug_wb_rf_wen}, 32'hF);
      chk("alu_wnum", {27'b0, debug_wb_rf_wnum}, 32'd5);
      chk("alu_wdata", debug_wb_rf_wdata, 32'h1234_5678);
      chk("alu_pc", debug_wb_pc, 32'hBFC0_0100);
      chk("alu_rf_bus_hi", {23'b0, ws_to_rf_bus[40:32]}, {23'b0, 4'hF, 5'd5});

      b = blank(); b.gr_strb = 4'b1100; b.dest = 5'd3; b.result = 32'hAABB_CCDD;
      b.pc = 32'hBFC0_0104;
      send(b);
      chk("lwl_we", {28'b0, debug_wb_rf_wen}, 32'hC);
      chk("lwl_fwd_valid", {28'b0, ws_fwd_bus[40:37]}, 32'hC);
      chk("lwl_fwd_data", ws_fwd_bus[31:0], 32'hAABB_CCDD);

      b = blank(); b.ex = 1'b1; b.bd = 1'b1; b.excode = EXC_ADEL;
      b.badvaddr = 32'h8000_0001; b.pc = 32'hBFC0_0204; b.gr_strb = 4'hF;
      b.mtc0 = 1'b1; b.cp0_addr = CR_EPC; b.result = 32'h1111_1111;
      send(b);
      chk("adel_ex", {31'b0, ws_ex}, 32'd1);
      chk("adel_rf_we", {28'b0, debug_wb_rf_wen}, 32'd0);
      chk("adel_flush_pc", ws_flush_pc, 32'hBFC0_0380);
      bubble();
      rd_cp0(CR_EPC, v);      chk("adel_epc", v, 32'hBFC0_0200);
      rd_cp0(CR_CAUSE, v);    chk("adel_cause", v, 32'h8000_0010);
      rd_cp0(CR_BADVADDR, v); chk("adel_badvaddr", v, 32'h8000_0001);
      rd_cp0(CR_STATUS, v);   chk("adel_status", v, 32'h0040_0002);

      b = blank(); b.ex = 1'b1; b.excode = EXC_ADES; b.badvaddr = 32'h0000_1234;
      b.pc = 32'hBFC0_0300;
      send(b);
      bubble();
      rd_cp0(CR_EPC, v);      chk("nest_epc", v, 32'hBFC0_0200);
      rd_cp0(CR_CAUSE, v);    chk("nest_cause", v, 32'h8000_0014);
      rd_cp0(CR_BADVADDR, v); chk("nest_badvaddr", v, 32'h0000_1234);

      b = blank(); b.eret = 1'b1; b.pc = 32'hBFC0_0400;
      send(b);
      chk("eret_flag", {30'b0, ws_ex, ws_eret}, 32'd1);
      chk("eret_flush_pc", ws_flush_pc, 32'hBFC0_0200);
      bubble();
      rd_cp0(CR_STATUS, v);   chk("eret_status", v, 32'h0040_0000);

      wr_cp0(CR_STATUS, 32'hFFFF_8001);
      rd_cp0(CR_STATUS, v);   chk("status_mask", v, 32'h0040_8001);
      wr_cp0(CR_COUNT, 32'h0000_0100);
      rd_cp0(CR_COUNT, v);    chk("count_write", v, 32'h0000_0100);
      rd_cp0(CR_BADVADDR + 8'h01, v); chk("unmapped_rd", v, 32'h0);

      wr_cp0(CR_COUNT, 32'h0);
      wr_cp0(CR_COMPARE, 32'd3);
      bubble();
      chk("timer_before", {31'b0, ws_int_pending}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); #1;
         if (ws_int_pending) seen = 1'b1;
      end
      chk("timer_fires", {31'b0, seen}, 32'd1);
      rd_cp0(CR_CAUSE, v);    chk("timer_cause", v, 32'hC000_8014);
      wr_cp0(CR_COMPARE, 32'hFFFF_0000);
      bubble();
      chk("timer_clear", {31'b0, ws_int_pending}, 32'd0);

      ext_int_in = 6'b000001;
      rd_cp0(CR_CAUSE, v);    chk("ext_ip2", v, 32'h8000_0414);
      ext_int_in = 6'b0;
      wr_cp0(CR_CAUSE, 32'hFFFF_FFFF);
      rd_cp0(CR_CAUSE, v);    chk("cause_sw_ip", v, 32'h8000_0314);

      b = blank(); b.ex = 1'b1; b.excode = 5'd8; b.gr_strb = 4'hF; b.pc = 32'hBFC0_0500;
      send(b);
      chk("mid_ex_before", {31'b0, ws_ex}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_ex", {31'b0, ws_ex}, 32'd0);
      chk("mid_rst_we", {28'b0, debug_wb_rf_wen}, 32'd0);
      chk("mid_rst_int", {31'b0, ws_int_pending}, 32'd0);
      chk("mid_rst_flush", ws_flush_pc, 32'hBFC0_0380);
      @(negedge clk);
      ms_to_ws_valid = 1'b0; ms_to_ws_bus = '0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      rd_cp0(CR_STATUS, v);   chk("post_rst_status", v, 32'h0040_0000);
      rd_cp0(CR_EPC, v);      chk("post_rst_epc", v, 32'h0);
      rd_cp0(CR_BADVADDR, v); chk("post_rst_badvaddr", v, 32'h0);
      rd_cp0(CR_COMPARE, v);  chk("post_rst_compare", v, 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
